// File: rtl/pulse_sched_gen.sv
// pulse_sched_gen: microsecond time base scheduling cal/noise/train emit-receive strobes
module pulse_sched_gen #(
  parameter int TW        = 32,
  parameter int QW        = 16,
  parameter int NTEMP     = 3,
  parameter int PULSE_LEN = 4,
  parameter int TNC_GAP   = 8
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick_1us,
  input  logic                  sync_in,
  input  logic                  load,
  input  logic                  en_cal,
  input  logic                  en_noise,
  input  logic [3:0]            n_temp,
  input  logic [15:0]           cal_dly,
  input  logic [TW-1:0]         dt_cal,
  input  logic [TW-1:0]         dt_noise,
  input  logic [NTEMP*TW-1:0]   p_ni,
  input  logic [NTEMP*TW-1:0]   p_ii,
  input  logic [NTEMP*TW-1:0]   p_np,
  input  logic [NTEMP*TW-1:0]   p_ip,
  input  logic [NTEMP*QW-1:0]   qit,
  output logic                  tni,
  output logic                  tki,
  output logic                  tnp,
  output logic                  tkp,
  output logic                  tobm,
  output logic                  tnc,
  output logic                  i_izl,
  output logic                  i_get,
  output logic                  error,
  output logic                  busy,
  output logic [3:0]            cur_train,
  output logic [TW-1:0]         time_now
);
  localparam int CW = $clog2(PULSE_LEN + 1);
  localparam logic [4:0] P_END = 5'(NTEMP + 2);
  typedef enum logic [2:0] {IDLE, START, ARM, RUN, ENDW} state_t;
  state_t state;
  logic [2:0] s_tk, s_sy, s_ld;
  logic tk_r, sy_r, ld_r;
  logic sh_en_cal, sh_en_noise;
  logic [3:0] sh_n, n_eff, tk;
  logic [15:0] sh_cal_dly;
  logic [TW-1:0] sh_dt_cal, sh_dt_noise;
  logic [NTEMP*TW-1:0] sh_ni, sh_ii, sh_np, sh_ip;
  logic [NTEMP*QW-1:0] sh_qit;
  logic [4:0] pos;
  logic [QW-1:0] rep, q_cur;
  logic [TW-1:0] base, t_nx, a_ni, a_ki, a_np, a_kp;
  logic [TW-1:0] tgt [5];
  logic [CW-1:0] cnt [5];
  logic [4:0] pend, fire;
  logic [NTEMP+1:0] en_v;
  logic done;
  // positions: 0 = cal, 1 = noise, 2+k = train k, P_END = end
  function automatic logic [4:0] nxt(input logic [4:0] s, input logic [NTEMP+1:0] e);
    logic [4:0] r;
    r = P_END;
    for (int p = NTEMP + 1; p >= 0; p--) if (p >= int'(s) && e[p]) r = 5'(p);
    return r;
  endfunction
  assign tk_r = s_tk[1] & ~s_tk[2];
  assign sy_r = s_sy[1] & ~s_sy[2];
  assign ld_r = s_ld[1] & ~s_ld[2];
  assign t_nx = time_now + TW'(1);
  assign n_eff = sh_n > 4'(NTEMP) ? 4'(NTEMP) : sh_n;
  assign tk = (pos >= 5'd2 && pos < P_END) ? 4'(pos - 5'd2) : 4'd0;
  assign q_cur = pos < 5'd2 ? QW'(1) : sh_qit[tk*QW +: QW];
  assign done = (rep + QW'(1)) >= q_cur;
  always_comb begin
    en_v = '0;
    en_v[0] = sh_en_cal;
    en_v[1] = sh_en_noise;
    for (int k = 0; k < NTEMP; k++) en_v[k+2] = (k < int'(n_eff)) && (sh_qit[k*QW +: QW] != '0);
  end
  always_comb begin
    a_ni = base + sh_ni[tk*TW +: TW];
    a_ki = a_ni + sh_ii[tk*TW +: TW];
    a_np = pos < 5'd2 ? base + TW'(sh_cal_dly) : a_ki + sh_np[tk*TW +: TW];
    a_kp = a_np + (pos == 5'd0 ? sh_dt_cal : pos == 5'd1 ? sh_dt_noise : sh_ip[tk*TW +: TW]);
  end
  always_comb begin
    fire = '0;
    for (int i = 0; i < 5; i++) fire[i] = tk_r & ~sy_r & pend[i] & (t_nx == tgt[i]);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s_tk <= '0;
      s_sy <= '0;
      s_ld <= '0;
      sh_en_cal <= 1'b0;
      sh_en_noise <= 1'b0;
      sh_n <= '0;
      sh_cal_dly <= '0;
      sh_dt_cal <= '0;
      sh_dt_noise <= '0;
      sh_ni <= '0;
      sh_ii <= '0;
      sh_np <= '0;
      sh_ip <= '0;
      sh_qit <= '0;
    end else begin
      s_tk <= {s_tk[1:0], tick_1us};
      s_sy <= {s_sy[1:0], sync_in};
      s_ld <= {s_ld[1:0], load};
      if (ld_r) begin
        sh_en_cal <= en_cal;
        sh_en_noise <= en_noise;
        sh_n <= n_temp;
        sh_cal_dly <= cal_dly;
        sh_dt_cal <= dt_cal;
        sh_dt_noise <= dt_noise;
        sh_ni <= p_ni;
        sh_ii <= p_ii;
        sh_np <= p_np;
        sh_ip <= p_ip;
        sh_qit <= qit;
      end
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      pos <= '0;
      rep <= '0;
      base <= '0;
      time_now <= '0;
      tgt <= '{default: '0};
      cnt <= '{default: '0};
      pend <= '0;
      i_izl <= 1'b0;
      i_get <= 1'b0;
      error <= 1'b0;
    end else begin
      error <= ((fire[0] && i_get) || (fire[2] && i_izl)) ? 1'b1 : ld_r ? 1'b0 : error;
      if (sy_r) begin
        time_now <= '0;
        state <= START;
        pend <= '0;
        cnt <= '{default: '0};
        i_izl <= 1'b0;
        i_get <= 1'b0;
      end else begin
        if (tk_r) time_now <= t_nx;
        for (int i = 0; i < 5; i++)
          cnt[i] <= fire[i] ? CW'(PULSE_LEN) : (tk_r && cnt[i] != '0) ? cnt[i] - CW'(1) : cnt[i];
        i_izl <= fire[1] ? 1'b0 : fire[0] ? 1'b1 : i_izl;
        i_get <= fire[3] ? 1'b0 : fire[2] ? 1'b1 : i_get;
        pend <= pend & ~fire;
        case (state)
          START: begin
            base <= time_now;
            pos <= nxt(5'd0, en_v);
            rep <= '0;
            state <= ARM;
          end
          ARM: begin
            tgt[0] <= a_ni;
            tgt[1] <= a_ki;
            tgt[2] <= a_np;
            tgt[3] <= a_kp;
            tgt[4] <= base + TW'(TNC_GAP);
            pend <= pos == P_END ? 5'b10000 : pos < 5'd2 ? 5'b01100 : 5'b01111;
            state <= pos == P_END ? ENDW : RUN;
          end
          RUN:
            if (fire[3]) begin
              base <= tgt[3];
              rep <= done ? '0 : rep + QW'(1);
              pos <= done ? nxt(pos + 5'd1, en_v) : pos;
              state <= ARM;
            end
          ENDW: if (fire[4]) state <= START;
          default: ;
        endcase
      end
    end
  assign tni = cnt[0] != '0;
  assign tki = cnt[1] != '0;
  assign tnp = cnt[2] != '0;
  assign tkp = cnt[3] != '0;
  assign tobm = cnt[3] != '0;
  assign tnc = cnt[4] != '0;
  assign busy = state != IDLE;
  assign cur_train = (state == ARM || state == RUN) ? tk : 4'd0;
endmodule

// File: tb/tb_pulse_sched_gen.sv
// tb_pulse_sched_gen: table-driven directed vectors plus corner sequences for pulse_sched_gen
module tb_pulse_sched_gen;
  localparam int TW = 8, QW = 16, NT = 3;
  localparam logic [5:0] NI = 6'd1, KI = 6'd2, NP = 6'd4, KPOB = 6'd24, NC = 6'd32;
  logic clk = 0, rst = 1, tick_1us = 0, sync_in = 0, load = 0, en_cal = 0, en_noise = 0;
  logic [3:0] n_temp = 0;
  logic [15:0] cal_dly = 0;
  logic [TW-1:0] dt_cal = 0, dt_noise = 0;
  logic [NT*TW-1:0] p_ni = 0, p_ii = 0, p_np = 0, p_ip = 0;
  logic [NT*QW-1:0] qit = 0;
  logic tni, tki, tnp, tkp, tobm, tnc, i_izl, i_get, error, busy;
  logic [3:0] cur_train;
  logic [TW-1:0] time_now;
  logic [5:0] mask;
  int passed = 0, total = 0;
  typedef struct {int scn; int n; logic [7:0] t; logic [5:0] m; logic izl; logic get; logic err;} vec_t;
  vec_t v[$];
  pulse_sched_gen #(.TW(TW), .QW(QW), .NTEMP(NT), .PULSE_LEN(4), .TNC_GAP(8)) dut (
    .clk(clk), .rst(rst), .tick_1us(tick_1us), .sync_in(sync_in), .load(load),
    .en_cal(en_cal), .en_noise(en_noise), .n_temp(n_temp), .cal_dly(cal_dly),
    .dt_cal(dt_cal), .dt_noise(dt_noise), .p_ni(p_ni), .p_ii(p_ii), .p_np(p_np),
    .p_ip(p_ip), .qit(qit), .tni(tni), .tki(tki), .tnp(tnp), .tkp(tkp), .tobm(tobm),
    .tnc(tnc), .i_izl(i_izl), .i_get(i_get), .error(error), .busy(busy),
    .cur_train(cur_train), .time_now(time_now)
  );
  assign mask = {tnc, tobm, tkp, tnp, tki, tni};
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  task automatic step(input int n);
    repeat (n) begin
      tick_1us = 1;
      repeat (4) @(negedge clk);
      tick_1us = 0;
      repeat (4) @(negedge clk);
    end
  endtask
  task automatic pulse_sync;
    sync_in = 1;
    repeat (4) @(negedge clk);
    sync_in = 0;
    repeat (4) @(negedge clk);
  endtask
  task automatic pulse_load;
    load = 1;
    repeat (4) @(negedge clk);
    load = 0;
    repeat (4) @(negedge clk);
  endtask
  // scn 0: cal only; 1: train0 x2, train1 skipped; 2: overlap; 3: train0 skipped
  task automatic cfg(input int scn);
    en_cal = (scn == 0);
    en_noise = 0;
    cal_dly = 16'd5;
    dt_cal = 8'd10;
    dt_noise = 8'd0;
    n_temp = scn == 0 ? 4'd0 : scn == 2 ? 4'd1 : 4'd2;
    p_ni = {8'd0, 8'd3, 8'd2};
    p_ii = {8'd0, 8'd2, 8'd3};
    p_np = {8'd0, 8'd1, scn == 2 ? 8'd0 : 8'd1};
    p_ip = {8'd0, 8'd1, scn == 2 ? 8'd2 : 8'd4};
    qit = scn == 3 ? {16'd0, 16'd1, 16'd0} : scn == 2 ? {16'd0, 16'd0, 16'd1} : {16'd5, 16'd0, 16'd2};
    pulse_load;
    pulse_sync;
  endtask
  initial begin
    #1000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("reset", {mask, i_izl, i_get, error, busy, cur_train, time_now}, 64'd0);
    rst = 0;
    v.push_back('{0, 4, 8'd4, 6'd0, 1'b0, 1'b0, 1'b0});
    v.push_back('{0, 1, 8'd5, NP, 1'b0, 1'b1, 1'b0});
    v.push_back('{0, 10, 8'd15, KPOB, 1'b0, 1'b0, 1'b0});
    v.push_back('{0, 8, 8'd23, NC, 1'b0, 1'b0, 1'b0});
    v.push_back('{0, 5, 8'd28, NP, 1'b0, 1'b1, 1'b0});
    v.push_back('{1, 1, 8'd1, 6'd0, 1'b0, 1'b0, 1'b0});
    v.push_back('{1, 1, 8'd2, NI, 1'b1, 1'b0, 1'b0});
    v.push_back('{1, 3, 8'd5, NI | KI, 1'b0, 1'b0, 1'b0});
    v.push_back('{1, 1, 8'd6, KI | NP, 1'b0, 1'b1, 1'b0});
    v.push_back('{1, 3, 8'd9, NP, 1'b0, 1'b1, 1'b0});
    v.push_back('{1, 1, 8'd10, KPOB, 1'b0, 1'b0, 1'b0});
    v.push_back('{1, 2, 8'd12, KPOB | NI, 1'b1, 1'b0, 1'b0});
    v.push_back('{1, 8, 8'd20, KPOB, 1'b0, 1'b0, 1'b0});
    v.push_back('{1, 8, 8'd28, NC, 1'b0, 1'b0, 1'b0});
    v.push_back('{1, 2, 8'd30, NC | NI, 1'b1, 1'b0, 1'b0});
    v.push_back('{2, 4, 8'd4, NI, 1'b1, 1'b0, 1'b0});
    v.push_back('{2, 1, 8'd5, NI | KI | NP, 1'b0, 1'b1, 1'b1});
    v.push_back('{2, 2, 8'd7, KI | NP | KPOB, 1'b0, 1'b0, 1'b1});
    v.push_back('{2, 3, 8'd10, KPOB, 1'b0, 1'b0, 1'b1});
    for (int i = 0; i < v.size(); i++) begin
      if (i == 0 || v[i].scn != v[i-1].scn) cfg(v[i].scn);
      step(v[i].n);
      chk($sformatf("vec%0d", i), {time_now, mask, i_izl, i_get, error},
          {v[i].t, v[i].m, v[i].izl, v[i].get, v[i].err});
    end
    pulse_load;
    chk("err_clear", error, 1'b0);
    cfg(1);
    step(6);
    chk("pre_sync", {mask, i_get}, {KI | NP, 1'b1});
    pulse_sync;
    chk("sync_mid", {time_now, mask, i_izl, i_get, busy}, {8'd0, 6'd0, 1'b0, 1'b0, 1'b1});
    step(2);
    chk("sync_restart", {time_now, mask}, {8'd2, NI});
    step(10);
    #2 rst = 1;
    #1 chk("async_rst", {mask, i_izl, i_get, error, busy, cur_train, time_now}, 64'd0);
    @(negedge clk) rst = 0;
    step(3);
    chk("post_rst", {time_now, mask, busy}, {8'd3, 6'd0, 1'b0});
    cfg(3);
    chk("cur_train", cur_train, 4'd1);
    step(3);
    chk("train1_tni", {time_now, mask}, {8'd3, NI});
    cfg(0);
    step(253);
    chk("wrap_base", {time_now, mask}, {8'd253, NC});
    step(4);
    chk("wrap_zero", {time_now, mask}, {8'd1, 6'd0});
    step(1);
    chk("wrap_tnp", {time_now, mask, i_get}, {8'd2, NP, 1'b1});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
